// File: rtl/mimo_gear_pkg.sv
// rtl/mimo_gear_pkg.sv - shared state type and helpers for the mimo_gear element gearbox
package mimo_gear_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/mimo_gear_window.sv
// rtl/mimo_gear_window.sv - combinational head window: rotate the buffer from rd_ptr, zero lanes at/after out_count
module mimo_gear_window
  import mimo_gear_pkg::*;
#(
  parameter int ELEM      = 8,
  parameter int OUT_LANES = 16,
  parameter int DEPTH     = 32
) (
  input  logic [DEPTH*ELEM-1:0]            store_flat,
  input  logic [$clog2(DEPTH)-1:0]         rd_ptr,
  input  logic [$clog2(OUT_LANES+1)-1:0]   out_count,
  output logic [OUT_LANES*ELEM-1:0]        first
);

  localparam int AW = $clog2(DEPTH);

  // Pointer arithmetic wraps naturally because DEPTH is a power of two.
  always_comb begin
    first = '0;
    for (int i = 0; i < OUT_LANES; i++) begin
      if (i < int'(out_count))
        first[i*ELEM +: ELEM] = store_flat[int'(rd_ptr + AW'(i))*ELEM +: ELEM];
    end
  end

endmodule

// File: rtl/mimo_gear.sv
// rtl/mimo_gear.sv - multi-in/multi-out element gearbox; optional flush/drain under MIMO_GEAR_FLUSH_EN
module mimo_gear
  import mimo_gear_pkg::*;
#(
  parameter int ELEM      = 8,
  parameter int IN_LANES  = 4,
  parameter int OUT_LANES = 16,
  parameter int DEPTH     = 32
) (
  input  logic                               CLK,
  input  logic                               nRST,
  input  logic                               enq__ENA,
  output logic                               enq__RDY,
  input  logic [IN_LANES*ELEM-1:0]           enq_v,
  input  logic [$clog2(IN_LANES+1)-1:0]      enq_count,
  input  logic                               deq__ENA,
  output logic                               deq__RDY,
  output logic [OUT_LANES*ELEM-1:0]          first,
  output logic [$clog2(OUT_LANES+1)-1:0]     out_count,
  input  logic                               flush__ENA,
  output logic                               flush__RDY,
  output logic [$clog2(DEPTH+1)-1:0]         level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam int IW = $clog2(IN_LANES+1);
  localparam int CW = $clog2(OUT_LANES+1);

  if (((DEPTH & (DEPTH - 1)) != 0) || (DEPTH < IN_LANES + OUT_LANES)) begin : g_bad_depth
    $error("mimo_gear: DEPTH must be a power of two and at least IN_LANES+OUT_LANES");
  end

  logic [DEPTH-1:0][ELEM-1:0] store;
  logic [AW-1:0]              wr_ptr, rd_ptr;
  state_t                     state;
  logic [IW-1:0]              enq_n;
  logic                       enq_acc, deq_acc;
  logic [LW-1:0]              level_next;

  // Counts above IN_LANES are clamped so the write loop never runs past the lane vector.
  assign enq_n      = IW'(min_u(int'(enq_count), IN_LANES));
  assign enq__RDY   = (state == IDLE) && (int'(level) + IN_LANES <= DEPTH);
  assign deq__RDY   = (state == IDLE) ? (int'(level) >= OUT_LANES) : (level != '0);
  assign enq_acc    = enq__ENA && enq__RDY && (enq_n != '0);
  assign deq_acc    = deq__ENA && deq__RDY;
  assign level_next = level + (enq_acc ? LW'(enq_n) : '0) - (deq_acc ? LW'(out_count) : '0);

`ifdef MIMO_GEAR_FLUSH_EN
  logic flush_acc;

  assign flush__RDY = (state == IDLE);
  assign flush_acc  = flush__ENA && flush__RDY;
  assign out_count  = (state == IDLE) ? CW'(OUT_LANES) : CW'(min_u(int'(level), OUT_LANES));

  // level_next already folds in a same-cycle enq, so those elements join the drain.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (flush_acc && level_next != '0) state <= DRAIN;
        DRAIN:   if (level_next == '0) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`else
  logic unused_flush;

  assign unused_flush = flush__ENA;
  assign flush__RDY   = 1'b0;
  assign state        = IDLE;
  assign out_count    = CW'(OUT_LANES);
`endif

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      store  <= '0;
    end else begin
      if (enq_acc) begin
        for (int j = 0; j < IN_LANES; j++) begin
          if (j < int'(enq_n)) store[wr_ptr + AW'(j)] <= enq_v[j*ELEM +: ELEM];
        end
        wr_ptr <= wr_ptr + AW'(enq_n);
      end
      if (deq_acc) rd_ptr <= rd_ptr + AW'(out_count);
      level <= level_next;
    end
  end

  mimo_gear_window #(
    .ELEM      (ELEM),
    .OUT_LANES (OUT_LANES),
    .DEPTH     (DEPTH)
  ) u_window (
    .store_flat (store),
    .rd_ptr     (rd_ptr),
    .out_count  (out_count),
    .first      (first)
  );

endmodule

// File: doc/mimo_gear.md
MIMO_GEAR -- requirements
Module: mimo_gear

Interface
REQ-001 Parameter ELEM, default 8, element width in bits.
REQ-002 Parameter IN_LANES, default 4, maximum elements accepted per enq.
REQ-003 Parameter OUT_LANES, default 16, elements presented per deq.
REQ-004 Parameter DEPTH, default 32, buffer capacity in elements; SHALL be a power of two, at least IN_LANES+OUT_LANES, with elaboration error otherwise.
REQ-005 CLK  input  1  clock; all state SHALL update on its rising edge.
REQ-006 nRST  input  1  reset, synchronous, active-low.
REQ-007 enq__ENA  input  1  enqueue strobe; honoured only while enq__RDY=1.
REQ-008 enq__RDY  output  1  enqueue permitted.
REQ-009 enq_v  input  IN_LANES*ELEM  elements; lane 0 in the LSBs and oldest.
REQ-010 enq_count  input  $clog2(IN_LANES+1)  number of valid low lanes, 1..IN_LANES; 0 is a no-op.
REQ-011 deq__ENA  input  1  dequeue strobe; honoured only while deq__RDY=1.
REQ-012 deq__RDY  output  1  dequeue permitted.
REQ-013 first  output  OUT_LANES*ELEM  head window; lane 0 is the oldest element.
REQ-014 out_count  output  $clog2(OUT_LANES+1)  valid lanes in first.
REQ-015 flush__ENA  input  1  flush request; honoured only while flush__RDY=1.
REQ-016 flush__RDY  output  1  flush permitted.
REQ-017 level  output  $clog2(DEPTH+1)  elements currently held.

Function
REQ-018 Storage SHALL be a DEPTH-element circular buffer with wr_ptr, rd_ptr and level; pointers SHALL wrap modulo DEPTH.
REQ-019 enq__RDY SHALL be 1 when level+IN_LANES <= DEPTH and state is IDLE.
REQ-020 An accepted enq SHALL write lanes 0..enq_count-1 to wr_ptr.. in order and advance wr_ptr by enq_count.
REQ-021 In IDLE, deq__RDY SHALL be 1 when level >= OUT_LANES, and out_count SHALL equal OUT_LANES.
REQ-022 first SHALL present elements rd_ptr..rd_ptr+OUT_LANES-1 combinationally, with zero latency and correct across wrap.
REQ-023 An accepted deq SHALL advance rd_ptr by out_count.
REQ-024 Simultaneous accepted enq and deq SHALL both take effect: level_next = level + enq_count - out_count.
REQ-025 Lanes of first at or beyond out_count SHALL read as zero.
REQ-026 The state machine SHALL have two states, IDLE and DRAIN; flush__RDY SHALL be 1 only in IDLE.
REQ-027 An accepted flush in the same cycle as an accepted enq SHALL include the enqueued elements in the drain.
REQ-028 An accepted flush SHALL move to DRAIN when the resulting level > 0, and SHALL stay in IDLE otherwise.
REQ-029 In DRAIN: enq__RDY=0, deq__RDY=(level>0), out_count=min(level,OUT_LANES).
REQ-030 DRAIN SHALL return to IDLE on the deq that makes level 0.
REQ-031 Overflow and underflow SHALL be impossible by construction; an ENA asserted while RDY=0 SHALL be ignored.

Reset
REQ-032 While nRST=0 at a clock edge: wr_ptr=0, rd_ptr=0, level=0, state=IDLE. Buffer contents need not be cleared.
REQ-033 Reset outputs SHALL be enq__RDY=1, deq__RDY=0, flush__RDY=1 (macro set), level=0, first=0.
REQ-034 Reset mid-drain SHALL discard all held elements.

Configuration
REQ-035 With macro MIMO_GEAR_FLUSH_EN defined: flush and DRAIN behave as specified above.
REQ-036 Without MIMO_GEAR_FLUSH_EN: flush__RDY=0, flush__ENA is ignored, state is constant IDLE, and out_count is constant OUT_LANES.

Structure
REQ-037 Package mimo_gear_pkg SHALL hold the state typedef (IDLE, DRAIN) and a min helper function.
REQ-038 Sub-module mimo_gear_window SHALL implement the combinational read window: a rotate from rd_ptr plus zero masking by out_count.

Verification
REQ-039 Reset, then enqueue four times with enq_count=4 and elements 0x00..0x0F -> deq__RDY=1 after the fourth, first=0x0F0E..0100, level=16.
REQ-040 Keep level=20, then enqueue 4 while dequeuing 16 in the same cycle -> level=8, and order is preserved.
REQ-041 Push 40 elements through with mixed counts 1/3/4 and pointers crossing 31->0 -> output sequence equals input sequence.
REQ-042 Fill to level=29 -> enq__RDY=0; one deq -> enq__RDY=1.
REQ-043 With the macro set, enqueue 5 then flush -> out_count=5, upper 11 lanes zero, deq returns to IDLE with level=0; without the macro, flush has no effect.
REQ-044 Assert nRST=0 while in DRAIN with level=3 -> next cycle level=0, IDLE, deq__RDY=0.
